// File: rtl/pcie_ltssm_pkg.sv
// Shared symbol constants and lane-parser types for the LTSSM ordered-set receiver.
package pcie_ltssm_pkg;

  localparam logic [7:0] COM    = 8'hBC;
  localparam logic [7:0] PAD    = 8'hF7;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;
  localparam logic [7:0] IDLE   = 8'h00;

  typedef enum logic {
    LANE_SCAN,
    LANE_OS
  } lane_state_t;

  typedef enum logic [1:0] {
    TS_NONE,
    TS_TS1,
    TS_TS2
  } ts_type_t;

  function automatic logic is_k_sym(input logic [7:0] data, input logic k,
                                    input logic [7:0] sym);
    return k && (data == sym);
  endfunction

endpackage

// File: rtl/ltssm_os_rx_lane.sv
// Single-lane TS1/TS2 ordered-set parser with consecutive-set counting and idle tracking.
module ltssm_os_rx_lane
  import pcie_ltssm_pkg::*;
#(
  parameter int TS1_REQ  = 2,
  parameter int TS2_REQ  = 8,
  parameter int IDLE_REQ = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sym_valid,
  input  logic [7:0] sym_data,
  input  logic       sym_k,
  output logic       ts1_sat,
  output logic       ts2_sat,
  output logic [7:0] link_num,
  output logic       link_pad,
  output logic [7:0] lane_num,
  output logic       lane_pad,
  output logic       idle_hit,
  output logic       idle_sat
);

  localparam int IDLE_W = $clog2(IDLE_REQ + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_REQ);

  lane_state_t       state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic              bad_q, bad_d;
  ts_type_t          cur_type_q, cur_type_d;
  logic [7:0]        cur_link_q, cur_link_d;
  logic              cur_link_pad_q, cur_link_pad_d;
  logic [7:0]        cur_lane_q, cur_lane_d;
  logic              cur_lane_pad_q, cur_lane_pad_d;
  ts_type_t          type_q, type_d;
  logic [3:0]        count_q, count_d;
  logic [7:0]        link_q, link_d;
  logic              link_pad_q, link_pad_d;
  logic [7:0]        lane_q, lane_d;
  logic              lane_pad_q, lane_pad_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  logic              sym_bad;
  ts_type_t          sym_type;
  logic              same_as_prev;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state_q        <= LANE_SCAN;
      idx_q          <= '0;
      bad_q          <= 1'b0;
      cur_type_q     <= TS_NONE;
      cur_link_q     <= '0;
      cur_link_pad_q <= 1'b0;
      cur_lane_q     <= '0;
      cur_lane_pad_q <= 1'b0;
      type_q         <= TS_NONE;
      count_q        <= '0;
      link_q         <= '0;
      link_pad_q     <= 1'b0;
      lane_q         <= '0;
      lane_pad_q     <= 1'b0;
      idle_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      bad_q          <= bad_d;
      cur_type_q     <= cur_type_d;
      cur_link_q     <= cur_link_d;
      cur_link_pad_q <= cur_link_pad_d;
      cur_lane_q     <= cur_lane_d;
      cur_lane_pad_q <= cur_lane_pad_d;
      type_q         <= type_d;
      count_q        <= count_d;
      link_q         <= link_d;
      link_pad_q     <= link_pad_d;
      lane_q         <= lane_d;
      lane_pad_q     <= lane_pad_d;
      idle_cnt_q     <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    bad_d          = bad_q;
    cur_type_d     = cur_type_q;
    cur_link_d     = cur_link_q;
    cur_link_pad_d = cur_link_pad_q;
    cur_lane_d     = cur_lane_q;
    cur_lane_pad_d = cur_lane_pad_q;
    type_d         = type_q;
    count_d        = count_q;
    link_d         = link_q;
    link_pad_d     = link_pad_q;
    lane_d         = lane_q;
    lane_pad_d     = lane_pad_q;
    idle_cnt_d     = idle_cnt_q;
    idle_hit       = 1'b0;
    sym_bad        = 1'b0;
    sym_type       = cur_type_q;
    same_as_prev   = 1'b0;

    if (sym_valid) begin
      if (is_k_sym(sym_data, sym_k, COM)) begin
        // COM always restarts the set, whatever was in flight.
        state_d    = LANE_OS;
        idx_d      = 4'd1;
        bad_d      = 1'b0;
        cur_type_d = TS_NONE;
        idle_cnt_d = '0;
      end else if (state_q == LANE_SCAN) begin
        if (!sym_k && sym_data == IDLE) begin
          idle_hit = 1'b1;
          if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
          idle_cnt_d = '0;
        end
      end else begin
        idle_cnt_d = '0;
        idx_d      = idx_q + 4'd1;
        case (idx_q)
          4'd1: begin
            if (sym_k && sym_data != PAD) sym_bad = 1'b1;
            cur_link_d     = sym_data;
            cur_link_pad_d = sym_k;
          end
          4'd2: begin
            if (sym_k && sym_data != PAD) sym_bad = 1'b1;
            cur_lane_d     = sym_data;
            cur_lane_pad_d = sym_k;
          end
          4'd3, 4'd4, 4'd5: begin
            if (sym_k) sym_bad = 1'b1;
          end
          default: begin
            if (sym_k) begin
              sym_bad = 1'b1;
            end else if (idx_q == 4'd6) begin
              if (sym_data == TS1_ID)      sym_type = TS_TS1;
              else if (sym_data == TS2_ID) sym_type = TS_TS2;
              else                         sym_bad  = 1'b1;
            end else if (!((cur_type_q == TS_TS1 && sym_data == TS1_ID) ||
                           (cur_type_q == TS_TS2 && sym_data == TS2_ID))) begin
              sym_bad = 1'b1;
            end
          end
        endcase
        cur_type_d = sym_type;
        bad_d      = bad_q | sym_bad;

        if (idx_q == 4'd15) begin
          state_d      = LANE_SCAN;
          idx_d        = '0;
          same_as_prev = (sym_type == type_q) &&
                         ({cur_link_pad_q, cur_link_q} == {link_pad_q, link_q}) &&
                         ({cur_lane_pad_q, cur_lane_q} == {lane_pad_q, lane_q});
          if (bad_q || sym_bad) begin
            count_d = '0;
            type_d  = TS_NONE;
          end else if (same_as_prev) begin
            if (count_q != 4'd15) count_d = count_q + 4'd1;
          end else begin
            count_d    = 4'd1;
            type_d     = sym_type;
            link_d     = cur_link_q;
            link_pad_d = cur_link_pad_q;
            lane_d     = cur_lane_q;
            lane_pad_d = cur_lane_pad_q;
          end
        end
      end
    end
  end

  assign ts1_sat  = (type_q == TS_TS1) && (32'(count_q) >= 32'(TS1_REQ));
  assign ts2_sat  = (type_q == TS_TS2) && (32'(count_q) >= 32'(TS2_REQ));
  assign link_num = link_q;
  assign link_pad = link_pad_q;
  assign lane_num = lane_q;
  assign lane_pad = lane_pad_q;
  assign idle_sat = (idle_cnt_q == IDLE_MAX);

endmodule

// File: rtl/ltssm_os_rx.sv
// Multi-lane TS1/TS2/idle receiver: per-lane parsers plus link-wide formation checks.
module ltssm_os_rx
  import pcie_ltssm_pkg::*;
#(
  parameter int MAX_NUM_LANES = 4,
  parameter int DATA_WIDTH    = 8 * MAX_NUM_LANES,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int USER_WIDTH    = 5,
  parameter int TS1_REQ       = 2,
  parameter int TS2_REQ       = 8,
  parameter int IDLE_REQ      = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata_i,
  input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep_i,
  input  logic                     s_axis_tvalid_i,
  input  logic [USER_WIDTH-1:0]    s_axis_tuser_i,
  output logic                     s_axis_tready_o,
  output logic [MAX_NUM_LANES-1:0] lanes_ts1_satisfied_o,
  output logic [MAX_NUM_LANES-1:0] lanes_ts2_satisfied_o,
  output logic [MAX_NUM_LANES-1:0] config_copmlete_ts2_o,
  output logic                     link_lanes_formed_o,
  output logic                     link_lanes_nums_match_o,
  output logic                     single_idle_recieved_o,
  output logic                     link_idle_satisfied_o
);

  logic                     tready_q;
  logic                     single_idle_q;
  logic [MAX_NUM_LANES-1:0] ts1_sat;
  logic [MAX_NUM_LANES-1:0] ts2_sat;
  logic [MAX_NUM_LANES-1:0] link_pad;
  logic [MAX_NUM_LANES-1:0] lane_pad;
  logic [MAX_NUM_LANES-1:0] idle_hit;
  logic [MAX_NUM_LANES-1:0] idle_sat;
  logic [7:0]               link_num [MAX_NUM_LANES];
  logic [7:0]               lane_num [MAX_NUM_LANES];
  logic [MAX_NUM_LANES-1:0] lane_sat;
  logic                     any_sat;
  logic                     link_ok;
  logic                     nums_ok;
  logic [7:0]               ref_link;
  logic                     unused_in;

  for (genvar g = 0; g < MAX_NUM_LANES; g++) begin : g_lane
    ltssm_os_rx_lane #(
      .TS1_REQ  (TS1_REQ),
      .TS2_REQ  (TS2_REQ),
      .IDLE_REQ (IDLE_REQ)
    ) u_lane (
      .clk       (clk_i),
      .rst       (rst_i),
      .en        (en_i),
      .sym_valid (s_axis_tvalid_i & tready_q & s_axis_tkeep_i[g]),
      .sym_data  (s_axis_tdata_i[8*g +: 8]),
      .sym_k     (s_axis_tuser_i[g]),
      .ts1_sat   (ts1_sat[g]),
      .ts2_sat   (ts2_sat[g]),
      .link_num  (link_num[g]),
      .link_pad  (link_pad[g]),
      .lane_num  (lane_num[g]),
      .lane_pad  (lane_pad[g]),
      .idle_hit  (idle_hit[g]),
      .idle_sat  (idle_sat[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) tready_q <= 1'b0;
    else       tready_q <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) single_idle_q <= 1'b0;
    else                single_idle_q <= |idle_hit;
  end

  // Status below depends only on lane flops, so it lands the cycle after the deciding beat.
  always_comb begin
    lane_sat = ts1_sat | ts2_sat;
    any_sat  = 1'b0;
    link_ok  = 1'b1;
    nums_ok  = 1'b1;
    ref_link = '0;
    for (int unsigned i = 0; i < MAX_NUM_LANES; i++) begin
      if (lane_sat[i]) begin
        if (link_pad[i]) link_ok = 1'b0;
        if (!any_sat) ref_link = link_num[i];
        else if (link_num[i] != ref_link) link_ok = 1'b0;
        if (lane_pad[i] || lane_num[i] != 8'(i)) nums_ok = 1'b0;
        any_sat = 1'b1;
      end
    end
  end

  always_comb begin
    config_copmlete_ts2_o = '0;
    for (int unsigned i = 0; i < MAX_NUM_LANES; i++) begin
      config_copmlete_ts2_o[i] = ts2_sat[i] && !link_pad[i] && !lane_pad[i] &&
                                 (lane_num[i] == 8'(i));
    end
  end

  assign s_axis_tready_o         = tready_q;
  assign lanes_ts1_satisfied_o   = ts1_sat;
  assign lanes_ts2_satisfied_o   = ts2_sat;
  assign link_lanes_formed_o     = any_sat && link_ok;
  assign link_lanes_nums_match_o = any_sat && link_ok && nums_ok;
  assign single_idle_recieved_o  = single_idle_q;
  assign link_idle_satisfied_o   = &idle_sat;

  assign unused_in = ^{s_axis_tdata_i, s_axis_tkeep_i, s_axis_tuser_i};

endmodule

// File: tb/tb_ltssm_os_rx.sv
// Scoreboard bench for ltssm_os_rx: expected status queued per checkpoint, compared after the beat.
module tb_ltssm_os_rx;

  localparam logic [7:0]  C_COM   = 8'hBC;
  localparam logic [7:0]  C_PAD   = 8'hF7;
  localparam logic [7:0]  C_TS1   = 8'h4A;
  localparam logic [7:0]  C_TS2   = 8'h45;
  localparam logic [31:0] LINK0   = 32'h0000_0000;
  localparam logic [31:0] LANES   = 32'h0302_0100;
  localparam int          NO_BAD  = -1;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b1;
  logic [31:0] tdata = '0;
  logic [3:0]  tkeep = '0;
  logic        tvalid = 1'b0;
  logic [4:0]  tuser = '0;
  logic        tready;
  logic [3:0]  ts1, ts2, cfg;
  logic        formed, match, sidle, isat;

  typedef struct {
    string       name;
    logic [15:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ltssm_os_rx #(
    .MAX_NUM_LANES (4),
    .DATA_WIDTH    (32),
    .KEEP_WIDTH    (4),
    .USER_WIDTH    (5),
    .TS1_REQ       (2),
    .TS2_REQ       (8),
    .IDLE_REQ      (8)
  ) dut (
    .clk_i                   (clk),
    .rst_i                   (rst_i),
    .en_i                    (en_i),
    .s_axis_tdata_i          (tdata),
    .s_axis_tkeep_i          (tkeep),
    .s_axis_tvalid_i         (tvalid),
    .s_axis_tuser_i          (tuser),
    .s_axis_tready_o         (tready),
    .lanes_ts1_satisfied_o   (ts1),
    .lanes_ts2_satisfied_o   (ts2),
    .config_copmlete_ts2_o   (cfg),
    .link_lanes_formed_o     (formed),
    .link_lanes_nums_match_o (match),
    .single_idle_recieved_o  (sidle),
    .link_idle_satisfied_o   (isat)
  );

  function automatic logic [15:0] mk(input logic [3:0] t1, input logic [3:0] t2,
                                     input logic [3:0] c, input logic f, input logic m,
                                     input logic si, input logic is);
    return {t1, t2, c, f, m, si, is};
  endfunction

  function automatic logic [15:0] obs();
    return {ts1, ts2, cfg, formed, match, sidle, isat};
  endfunction

  task automatic push(input string n, input logic [15:0] v);
    exp_t e;
    e.name = n;
    e.vec  = v;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    tvalid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic [3:0] keep);
    @(negedge clk);
    tdata  = d;
    tuser  = {1'b1, k};
    tkeep  = keep;
    tvalid = 1'b1;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
  endtask

  task automatic ts_beat(input int j, input logic [7:0] id, input logic [31:0] link_v,
                         input logic [31:0] lane_v, input logic [3:0] lane_pad,
                         input int bad_idx, input logic [7:0] bad_val, input logic [3:0] keep);
    logic [31:0] d;
    logic [3:0]  k;
    d = '0;
    k = '0;
    for (int l = 0; l < 4; l++) begin
      if (j == 0) begin
        d[8*l +: 8] = C_COM;
        k[l]        = 1'b1;
      end else if (j == 1) begin
        d[8*l +: 8] = link_v[8*l +: 8];
      end else if (j == 2) begin
        d[8*l +: 8] = lane_pad[l] ? C_PAD : lane_v[8*l +: 8];
        k[l]        = lane_pad[l];
      end else if (j <= 5) begin
        d[8*l +: 8] = 8'(8'h10 + j);
      end else begin
        d[8*l +: 8] = id;
      end
      if (j == bad_idx) d[8*l +: 8] = bad_val;
    end
    drive_beat(d, k, keep);
  endtask

  task automatic send_ts(input logic [7:0] id, input logic [31:0] link_v,
                         input logic [31:0] lane_v, input logic [3:0] lane_pad,
                         input int bad_idx, input logic [7:0] bad_val, input logic [3:0] keep);
    for (int j = 0; j < 16; j++) ts_beat(j, id, link_v, lane_v, lane_pad, bad_idx, bad_val, keep);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    en_i  = 1'b1;
    idle_cycle();
    idle_cycle();
    rst_i = 1'b0;
    idle_cycle();
  endtask

  task automatic test_reset();
    exp_t e;
    rst_i = 1'b1;
    idle_cycle();
    idle_cycle();
    push("reset_status", mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
    e = exp_q.pop_front();
    n_checks++;
    if (obs() !== e.vec) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
    end
    n_checks++;
    if (tready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tready: got %b expected 0", tready);
    end
    rst_i = 1'b0;
    idle_cycle();
    n_checks++;
    if (tready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_tready: got %b expected 1", tready);
    end
  endtask

  task automatic test_ts1_pair();
    exp_t e;
    do_reset();
    push("ts1_one_set", mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
    send_ts(C_TS1, LINK0, LANES, 4'h0, NO_BAD, 8'h00, 4'hF);
    e = exp_q.pop_front();
    n_checks++;
    if (obs() !== e.vec) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
    end
    push("ts1_pair", mk(4'hF, 4'h0, 4'h0, 1, 1, 0, 0));
    send_ts(C_TS1, LINK0, LANES, 4'h0, NO_BAD, 8'h00, 4'hF);
    e = exp_q.pop_front();
    n_checks++;
    if (obs() !== e.vec) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
    end
  endtask

  task automatic test_ts1_numbering();
    exp_t e;
    do_reset();
    push("lane_num_mismatch", mk(4'hF, 4'h0, 4'h0, 1, 0, 0, 0));
    send_ts(C_TS1, LINK0, 32'h0303_0100, 4'h0, NO_BAD, 8'h00, 4'hF);
    send_ts(C_TS1, LINK0, 32'h0303_0100, 4'h0, NO_BAD, 8'h00, 4'hF);
    e = exp_q.pop_front();
    n_checks++;
    if (obs() !== e.vec) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
    end
    push("link5_first_set", mk(4'b1001, 4'h0, 4'h0, 1, 1, 0, 0));
    send_ts(C_TS1, 32'h0000_0500, LANES, 4'h0, NO_BAD, 8'h00, 4'hF);
    e = exp_q.pop_front();
    n_checks++;
    if (obs() !== e.vec) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
    end
    push("link_mismatch", mk(4'hF, 4'h0, 4'h0, 0, 0, 0, 0));
    send_ts(C_TS1, 32'h0000_0500, LANES, 4'h0, NO_BAD, 8'h00, 4'hF);
    e = exp_q.pop_front();
    n_checks++;
    if (obs() !== e.vec) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
    end
  endtask

  task automatic test_ts2();
    exp_t e;
    do_reset();
    for (int n = 1; n <= 8; n++) begin
      if (n == 7) push("ts2_seven", mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
      if (n == 8) push("ts2_eight", mk(4'h0, 4'hF, 4'hF, 1, 1, 0, 0));
      send_ts(C_TS2, LINK0, LANES, 4'h0, NO_BAD, 8'h00, 4'hF);
      if (n >= 7) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e.vec) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
        end
      end
    end
    push("ts2_lane_pad", mk(4'h0, 4'hF, 4'h0, 1, 0, 0, 0));
    for (int n = 1; n <= 8; n++) send_ts(C_TS2, LINK0, LANES, 4'hF, NO_BAD, 8'h00, 4'hF);
    e = exp_q.pop_front();
    n_checks++;
    if (obs() !== e.vec) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
    end
  endtask

  task automatic test_ts2_corrupt();
    exp_t e;
    do_reset();
    for (int n = 1; n <= 4; n++) send_ts(C_TS2, LINK0, LANES, 4'h0, NO_BAD, 8'h00, 4'hF);
    push("ts2_bad_fifth", mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
    send_ts(C_TS2, LINK0, LANES, 4'h0, 9, C_TS1, 4'hF);
    e = exp_q.pop_front();
    n_checks++;
    if (obs() !== e.vec) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
    end
    for (int n = 1; n <= 8; n++) begin
      if (n == 7) push("ts2_seven_after_bad", mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
      if (n == 8) push("ts2_eight_after_bad", mk(4'h0, 4'hF, 4'hF, 1, 1, 0, 0));
      send_ts(C_TS2, LINK0, LANES, 4'h0, NO_BAD, 8'h00, 4'hF);
      if (n >= 7) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e.vec) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
        end
      end
    end
  endtask

  task automatic test_idle();
    exp_t e;
    do_reset();
    for (int b = 1; b <= 8; b++) begin
      if (b == 1) push("idle_beat1", mk(4'h0, 4'h0, 4'h0, 0, 0, 1, 0));
      if (b == 7) push("idle_beat7", mk(4'h0, 4'h0, 4'h0, 0, 0, 1, 0));
      if (b == 8) push("idle_beat8", mk(4'h0, 4'h0, 4'h0, 0, 0, 1, 1));
      drive_beat(32'h0, 4'h0, 4'hF);
      if (b == 1 || b >= 7) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e.vec) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
        end
      end
    end
    push("idle_gap", mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 1));
    idle_cycle();
    e = exp_q.pop_front();
    n_checks++;
    if (obs() !== e.vec) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
    end
    do_reset();
    for (int b = 1; b <= 13; b++) begin
      if (b == 8)  push("idle_break_b8", mk(4'h0, 4'h0, 4'h0, 0, 0, 1, 0));
      if (b == 12) push("idle_break_b12", mk(4'h0, 4'h0, 4'h0, 0, 0, 1, 0));
      if (b == 13) push("idle_break_b13", mk(4'h0, 4'h0, 4'h0, 0, 0, 1, 1));
      drive_beat((b == 5) ? 32'h0100_0000 : 32'h0, 4'h0, 4'hF);
      if (b == 8 || b >= 12) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e.vec) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
        end
      end
    end
  endtask

  task automatic test_keep();
    exp_t e;
    do_reset();
    push("keep_lane3_off", mk(4'b0111, 4'h0, 4'h0, 1, 1, 0, 0));
    send_ts(C_TS1, LINK0, LANES, 4'h0, NO_BAD, 8'h00, 4'b0111);
    send_ts(C_TS1, LINK0, LANES, 4'h0, NO_BAD, 8'h00, 4'b0111);
    e = exp_q.pop_front();
    n_checks++;
    if (obs() !== e.vec) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
    end
  endtask

  task automatic test_abort();
    exp_t e;
    do_reset();
    send_ts(C_TS1, LINK0, LANES, 4'h0, NO_BAD, 8'h00, 4'hF);
    send_ts(C_TS1, LINK0, LANES, 4'h0, NO_BAD, 8'h00, 4'hF);
    for (int pass = 0; pass < 2; pass++) begin
      for (int j = 0; j < 7; j++) ts_beat(j, C_TS1, LINK0, LANES, 4'h0, NO_BAD, 8'h00, 4'hF);
      if (pass == 0) rst_i = 1'b1;
      else           en_i  = 1'b0;
      push(pass == 0 ? "abort_rst" : "abort_en", mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
      ts_beat(7, C_TS1, LINK0, LANES, 4'h0, NO_BAD, 8'h00, 4'hF);
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e.vec) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
      end
      n_checks++;
      if (tready !== (pass == 0 ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL abort_tready_%0d: got %b expected %b", pass, tready, pass != 0);
      end
      rst_i = 1'b0;
      en_i  = 1'b1;
      idle_cycle();
      push("abort_resume_one", mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
      send_ts(C_TS1, LINK0, LANES, 4'h0, NO_BAD, 8'h00, 4'hF);
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e.vec) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
      end
      push("abort_resume_pair", mk(4'hF, 4'h0, 4'h0, 1, 1, 0, 0));
      send_ts(C_TS1, LINK0, LANES, 4'h0, NO_BAD, 8'h00, 4'hF);
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e.vec) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, obs(), e.vec);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ts1_pair();
    test_ts1_numbering();
    test_ts2();
    test_ts2_corrupt();
    test_idle();
    test_keep();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
